button_events: RTL and testbench

Debounces the board push-button and turns it into clean, single-cycle event pulses. It is the input-side counterpart of the LED drivers.
- Synchronizes the raw `btn` pin into `sysclk`.
- Qualifies each level change against a stability window.
- Reports press, release and long-press events plus a running press count.
- Sits between the top-level pin and any control logic, such as mode selection or LED pattern stepping.

---
 rtl/teachee_io_pkg.sv | 16 +
 rtl/button_events_bit_sync.sv | 27 ++
 rtl/button_events.sv | 146 ++++++++++++++
 tb/tb_button_events.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/teachee_io_pkg.sv
// Shared I/O definitions for the board-level pin handling blocks.
package teachee_io_pkg;

   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      PRESS_PENDING   = 2'd1,
      PRESSED         = 2'd2,
      RELEASE_PENDING = 2'd3
   } btn_state_t;

   localparam int unsigned SYSCLK_HZ              = 12000000;
   // 1 ms stability window and 1 s hold time at SYSCLK_HZ
   localparam int unsigned BTN_DEBOUNCE_DEFAULT   = SYSCLK_HZ / 1000;
   localparam int unsigned BTN_LONG_PRESS_DEFAULT = SYSCLK_HZ;

endpackage

// File: rtl/button_events_bit_sync.sv
// Two-flop synchronizer for asynchronous input pins; reusable for any width.
module bit_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two-stage capture of the asynchronous pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_events.sv
// Push-button debouncer producing press / release / long-press pulses and a
// wrapping press counter. All outputs are registered.
module button_events
   import teachee_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
   parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_DEFAULT
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       btn,
   output logic       btn_level,
   output logic       press,
   // "release" is a reserved word in SystemVerilog, hence the suffix
   output logic       release_pulse,
   output logic       long_press,
   output logic [7:0] press_count,
   output btn_state_t dbg_state
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

   logic              btn_s;
   btn_state_t        state_q, state_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_done_q, long_done_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic [7:0]        count_q, count_d;

   bit_sync #(.WIDTH(1)) u_sync (
      .clk   (sysclk),
      .rst_n (rst_n),
      .d     (btn),
      .q     (btn_s)
   );

   // Next-state logic: debounce FSM, hold timer and event pulses.
   always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      count_d     = count_q;

      // The hold timer runs whenever the debounced level is high; it
      // saturates so a very long hold can never re-trigger long_press.
      if (state_q == PRESSED || state_q == RELEASE_PENDING) begin
         if (hold_q == HOLD_LAST && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
         end
         if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
         end
      end

      case (state_q)
         RELEASED: begin
            if (btn_s) begin
               state_d = PRESS_PENDING;
               deb_d   = '0;
            end
         end
         PRESS_PENDING: begin
            if (!btn_s) begin
               state_d = RELEASED;
            end else if (deb_q == DEB_LAST) begin
               state_d     = PRESSED;
               level_d     = 1'b1;
               press_d     = 1'b1;
               count_d     = count_q + 8'd1;
               hold_d      = '0;
               long_done_d = 1'b0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = RELEASE_PENDING;
               deb_d   = '0;
            end
         end
         RELEASE_PENDING: begin
            // A bounce back high resumes the press without restarting hold_cnt.
            if (btn_s) begin
               state_d = PRESSED;
            end else if (deb_q == DEB_LAST) begin
               state_d   = RELEASED;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         default: begin
            state_d = RELEASED;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RELEASED;
         deb_q       <= '0;
         hold_q      <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         count_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         deb_q       <= deb_d;
         hold_q      <= hold_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         count_q     <= count_d;
      end
   end

   assign btn_level     = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign press_count   = count_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Outputs are sampled 1 time unit after each rising edge.
module tb_button_events;
   import teachee_io_pkg::*;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic       btn_level;
   logic       press;
   logic       release_pulse;
   logic       long_press;
   logic [7:0] press_count;
   btn_state_t dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int press_seen   = 0;
   int release_seen = 0;
   int long_seen    = 0;
   int p0, r0, l0;
   logic [7:0] exp_count;

   button_events #(
      .DEBOUNCE_CYCLES   (4),
      .LONG_PRESS_CYCLES (20)
   ) dut (
      .sysclk        (sysclk),
      .rst_n         (rst_n),
      .btn           (btn),
      .btn_level     (btn_level),
      .press         (press),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .press_count   (press_count),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   always #5 sysclk = ~sysclk;

   // pulse monitor: each pulse is one cycle wide, so one sample per cycle
   always @(negedge sysclk) begin
      if (press)         press_seen++;
      if (release_pulse) release_seen++;
      if (long_press)    long_seen++;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"}, 32'(btn_level), 32'd0);
      check({tag, "_press"}, 32'(press), 32'd0);
      check({tag, "_release"}, 32'(release_pulse), 32'd0);
      check({tag, "_long"}, 32'(long_press), 32'd0);
      check({tag, "_count"}, 32'(press_count), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'(RELEASED));
   endtask

   initial begin
      // 1: reset with button held, then fresh press after deassertion
      rst_n = 1'b0;
      btn   = 1'b1;
      exp_count = 8'd0;
      step(3);
      check_all_zero("rst_held");
      rst_n = 1'b1;
      step(6);
      check("rst_press_early", 32'(press), 32'd0);
      step(1);
      exp_count++;
      check("rst_press", 32'(press), 32'd1);
      check("rst_count", 32'(press_count), 32'(exp_count));
      step(1);
      check("rst_press_once", 32'(press), 32'd0);
      btn = 1'b0;
      step(7);
      check("rst_release", 32'(release_pulse), 32'd1);
      step(3);

      // 2: clean press held 40 cycles, long press 20 cycles after press
      p0 = press_seen; l0 = long_seen;
      btn = 1'b1;
      step(6);
      check("clean_press_early", 32'(press), 32'd0);
      check("clean_level_early", 32'(btn_level), 32'd0);
      step(1);
      exp_count++;
      check("clean_press", 32'(press), 32'd1);
      check("clean_level", 32'(btn_level), 32'd1);
      check("clean_count", 32'(press_count), 32'(exp_count));
      step(19);
      check("long_early", 32'(long_press), 32'd0);
      step(1);
      check("long_fire", 32'(long_press), 32'd1);
      step(1);
      check("long_once", 32'(long_press), 32'd0);
      step(12);
      check("clean_press_total", 32'(press_seen - p0), 32'd1);

      // 3: release glitch of 3 cycles is rejected, then a real release
      r0 = release_seen;
      btn = 1'b0;
      step(3);
      btn = 1'b1;
      step(10);
      check("glitch_no_release", 32'(release_seen - r0), 32'd0);
      check("glitch_level", 32'(btn_level), 32'd1);
      btn = 1'b0;
      step(6);
      check("release_early", 32'(release_pulse), 32'd0);
      check("release_level_early", 32'(btn_level), 32'd1);
      step(1);
      check("release_pulse", 32'(release_pulse), 32'd1);
      check("release_level", 32'(btn_level), 32'd0);
      step(3);
      check("long_no_repeat", 32'(long_seen - l0), 32'd1);

      // 4: bounce pattern 1,1,1,0,0,1,1,0 then 10 low cycles
      p0 = press_seen;
      btn = 1'b1; step(3);
      btn = 1'b0; step(2);
      btn = 1'b1; step(2);
      btn = 1'b0; step(11);
      check("bounce_no_press", 32'(press_seen - p0), 32'd0);
      check("bounce_level", 32'(btn_level), 32'd0);
      check("bounce_count", 32'(press_count), 32'(exp_count));

      // 5a: reset while in PRESS_PENDING
      btn = 1'b1;
      step(4);
      check("pend_state", 32'(dbg_state), 32'(PRESS_PENDING));
      rst_n = 1'b0;
      #1;
      exp_count = 8'd0;
      check_all_zero("rst_pend");
      btn = 1'b0;
      step(3);
      p0 = press_seen; r0 = release_seen; l0 = long_seen;
      rst_n = 1'b1;
      step(10);
      check("rst_pend_no_press", 32'(press_seen - p0), 32'd0);
      check("rst_pend_count", 32'(press_count), 32'd0);

      // 5b: reset while PRESSED
      btn = 1'b1;
      step(7);
      exp_count++;
      check("rst2_press", 32'(press), 32'd1);
      check("rst2_count", 32'(press_count), 32'(exp_count));
      step(2);
      check("pressed_state", 32'(dbg_state), 32'(PRESSED));
      btn   = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_count = 8'd0;
      check_all_zero("rst_pressed");
      step(3);
      p0 = press_seen; r0 = release_seen; l0 = long_seen;
      rst_n = 1'b1;
      step(25);
      check("rst2_no_press", 32'(press_seen - p0), 32'd0);
      check("rst2_no_release", 32'(release_seen - r0), 32'd0);
      check("rst2_no_long", 32'(long_seen - l0), 32'd0);
      check("rst2_level", 32'(btn_level), 32'd0);

      // 6: 256 clean press/release cycles, press_count wraps to 0
      p0 = press_seen;
      for (int i = 1; i <= 256; i++) begin
         btn = 1'b1;
         step(8);
         exp_count++;
         if (i == 255) check("wrap_255", 32'(press_count), 32'd255);
         if (i == 256) check("wrap_0", 32'(press_count), 32'd0);
         btn = 1'b0;
         step(8);
      end
      check("wrap_model", 32'(press_count), 32'(exp_count));
      check("wrap_press_total", 32'(press_seen - p0), 32'd256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
